regfile_port_arbiter: RTL and testbench

- Shares the block-RAM register file between the core pipeline and the host debug link.
- The register file has one write port and two synchronous read ports (A, B), each with 1-cycle read latency.
- The core always owns read port A and has priority on the write port and read port B.
- Host single-register reads/writes and a full 32-register dump sequence are scheduled into the cycles the core leaves free, with read-during-write forwarding.

---
 rtl/regfile_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares a block-RAM register file (one write port, two synchronous read
// ports A/B with 1-cycle latency) between the core pipeline and the host
// debug link. The core owns read port A outright and has priority on the
// write port and read port B. Host single-register accesses and a full
// register dump are slotted into the cycles the core leaves free. Reads
// issued in the same cycle as a write to the same address return the
// write data (forwarding); address 0 always reads as zero.
//
// Handshake: host_req is held with stable fields until host_ack pulses for
// one cycle; host_rdata is valid in that cycle for reads. dump_start is a
// single-cycle pulse; each dumped register is presented as a one-cycle
// dump_valid pulse with dump_addr/dump_data.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   core_write/wrAddr/wrData        core writeback request
//   core_rdAddrA                    core port-A address (pass-through)
//   core_rdAddrB, core_rdB_en       core port-B read request
//   host_req/we/addr/wdata          host request (held until ack)
//   host_ack, host_rdata            host completion pulse and read data
//   dump_start                      dump request pulse
//   dump_busy/valid/addr/data       dump status and output stream
//   rf_write/wrAddr/wrData          register-file write port
//   rf_rdAddrA, rf_rdAddrB          register-file read addresses
//   rf_rdDataB                      register-file port-B read data
//   dbg_state                       current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_wrAddr,
    input  logic [DATA_W-1:0] core_wrData,
    input  logic [ADDR_W-1:0] core_rdAddrA,
    input  logic [ADDR_W-1:0] core_rdAddrB,
    input  logic              core_rdB_en,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic [ADDR_W-1:0] rf_rdAddrA,
    output logic [ADDR_W-1:0] rf_rdAddrB,
    input  logic [DATA_W-1:0] rf_rdDataB,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_ACK     = 3'd2,
        S_DUMP    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_dump_pending;
    logic [ADDR_W-1:0] r_cnt;

    // Stage between read issue and read-data return (shared by host and dump).
    logic              r_p1_host;
    logic              r_p1_dump;
    logic [ADDR_W-1:0] r_p1_addr;
    logic              r_p1_fwd;
    logic [DATA_W-1:0] r_p1_fwd_data;

    logic [DATA_W-1:0] r_host_rdata;
    logic              r_dump_valid;
    logic [ADDR_W-1:0] r_dump_addr;
    logic [DATA_W-1:0] r_dump_data;

    logic              w_host_wr;
    logic              w_host_rd;
    logic              w_dump_rd;
    logic              w_start_dump;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_rd_result;

    // Grants: host write needs the write port, host/dump reads need port B.
    assign w_host_wr    = (r_state == S_IDLE) && host_req && host_we && !core_write;
    assign w_host_rd    = (r_state == S_IDLE) && host_req && !host_we && !core_rdB_en;
    assign w_dump_rd    = (r_state == S_DUMP) && !core_rdB_en;
    assign w_start_dump = (r_state == S_IDLE) && r_dump_pending && !host_req;
    assign w_rd_issue   = w_host_rd || w_dump_rd;

    // Write port: core wins; writes to address 0 are suppressed.
    assign w_wr_addr = core_write ? core_wrAddr : host_addr;
    assign w_wr_data = core_write ? core_wrData : host_wdata;
    assign w_wr_en   = (core_write || w_host_wr) && (w_wr_addr != '0);

    assign rf_write   = w_wr_en;
    assign rf_wrAddr  = w_wr_addr;
    assign rf_wrData  = w_wr_data;
    assign rf_rdAddrA = core_rdAddrA;

    // Read port B: core wins; otherwise the dump counter or host address.
    assign w_rd_addr  = (r_state == S_DUMP) ? r_cnt : host_addr;
    assign rf_rdAddrB = core_rdB_en ? core_rdAddrB : w_rd_addr;

    // The RAM returns the pre-write value on a same-cycle collision, so
    // remember the write data and substitute it when the data comes back.
    assign w_fwd_hit   = w_wr_en && (w_wr_addr == w_rd_addr);
    assign w_rd_result = (r_p1_addr == '0) ? '0 :
                         (r_p1_fwd ? r_p1_fwd_data : rf_rdDataB);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_host_wr)
                    w_next = S_ACK;
                else if (w_host_rd)
                    w_next = S_RD_WAIT;
                else if (w_start_dump)
                    w_next = S_DUMP;
            end
            S_RD_WAIT: w_next = S_ACK;
            S_ACK:     w_next = S_IDLE;
            S_DUMP: begin
                if (w_dump_rd && (r_cnt == LAST_ADDR))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Earlier entries may still be emerging; wait for the last one.
                if (r_dump_valid && (r_dump_addr == LAST_ADDR))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_dump_pending <= 1'b0;
            r_cnt          <= '0;
            r_p1_host      <= 1'b0;
            r_p1_dump      <= 1'b0;
            r_p1_addr      <= '0;
            r_p1_fwd       <= 1'b0;
            r_p1_fwd_data  <= '0;
            r_host_rdata   <= '0;
            r_dump_valid   <= 1'b0;
            r_dump_addr    <= '0;
            r_dump_data    <= '0;
        end else begin
            r_state <= w_next;

            // A new pulse arriving as a dump starts is kept as a further request.
            if (dump_start)
                r_dump_pending <= 1'b1;
            else if (w_start_dump)
                r_dump_pending <= 1'b0;

            if (w_start_dump)
                r_cnt <= '0;
            else if (w_dump_rd)
                r_cnt <= r_cnt + ADDR_W'(1);

            r_p1_host <= w_host_rd;
            r_p1_dump <= w_dump_rd;
            if (w_rd_issue) begin
                r_p1_addr     <= w_rd_addr;
                r_p1_fwd      <= w_fwd_hit;
                r_p1_fwd_data <= w_wr_data;
            end

            if (r_p1_host)
                r_host_rdata <= w_rd_result;

            r_dump_valid <= r_p1_dump;
            if (r_p1_dump) begin
                r_dump_addr <= r_p1_addr;
                r_dump_data <= w_rd_result;
            end
        end
    end

    assign host_ack   = (r_state == S_ACK);
    assign host_rdata = r_host_rdata;
    assign dump_busy  = r_dump_pending || (r_state == S_DUMP) || (r_state == S_DRAIN);
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Directed bench for regfile_port_arbiter. A behavioural synchronous RAM
// (read-before-write, 1-cycle latency) sits on the rf_* ports. Inputs are
// driven on the falling edge; outputs are sampled on the falling edge, so a
// "cycle" is one clock period ending at a rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              core_write;
  logic [ADDR_W-1:0] core_wrAddr;
  logic [DATA_W-1:0] core_wrData;
  logic [ADDR_W-1:0] core_rdAddrA;
  logic [ADDR_W-1:0] core_rdAddrB;
  logic              core_rdB_en;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wrAddr;
  logic [DATA_W-1:0] rf_wrData;
  logic [ADDR_W-1:0] rf_rdAddrA;
  logic [ADDR_W-1:0] rf_rdAddrB;
  logic [DATA_W-1:0] rf_rdDataB;
  logic [2:0]        dbg_state;

  regfile_port_arbiter #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .core_write(core_write), .core_wrAddr(core_wrAddr), .core_wrData(core_wrData),
    .core_rdAddrA(core_rdAddrA), .core_rdAddrB(core_rdAddrB), .core_rdB_en(core_rdB_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB), .rf_rdDataB(rf_rdDataB),
    .dbg_state(dbg_state)
  );

  // Register-file RAM model: synchronous read returns the pre-write value.
  logic [DATA_W-1:0] mem [NUM_REGS];
  always @(posedge clk) begin
    rf_rdDataB <= mem[rf_rdAddrB];
    if (rf_write) mem[rf_wrAddr] <= rf_wrData;
  end

  // scoreboard state
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk("hw_rf_write", rf_write, (a != 0) ? 1 : 0);
    if (a != 0) begin
      chk("hw_rf_wrAddr", rf_wrAddr, a);
      chk("hw_rf_wrData", rf_wrData, d);
    end
    @(negedge clk);
    chk("hw_ack", host_ack, 1);
    host_req = 1'b0;
    if (a != 0) shadow[a] = d;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    #1;
    chk("hr_rdAddrB", rf_rdAddrB, a);
    @(negedge clk);
    chk("hr_ack_early", host_ack, 0);
    @(negedge clk);
    chk("hr_ack", host_ack, 1);
    chk("hr_rdata", host_rdata, exp);
    host_req = 1'b0;
  endtask

  // Runs a dump; stalls port B on cycles s0/s1/s2 (counted from the cycle
  // after dump_start). abort_n != 0 asserts reset once that many pulses
  // have been seen.
  task automatic run_dump(input int s0, input int s1, input int s2,
                          input int nstall, input int abort_n);
    int got, first_c, last_c;
    bit aborted;
    logic [DATA_W-1:0] e;
    got = 0; first_c = 0; last_c = 0; aborted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(shadow[i]);
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    chk("dump_busy_start", dump_busy, 1);
    for (int c = 1; c <= 60 && !aborted; c++) begin
      if (got == NUM_REGS && c == last_c + 1) chk("dump_busy_fall", dump_busy, 0);
      if (dump_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("dump_addr", dump_addr, got);
        chk("dump_data", dump_data, e);
        if (got == 0) first_c = c;
        last_c = c;
        got++;
        if (got == NUM_REGS) chk("dump_busy_last", dump_busy, 1);
      end
      if (abort_n != 0 && got == abort_n) begin
        reset = 1'b1;
        core_rdB_en = 1'b0;
        aborted = 1'b1;
      end else begin
        core_rdB_en = (c == s0) || (c == s1) || (c == s2);
      end
      @(negedge clk);
    end
    core_rdB_en = 1'b0;
    if (aborted) begin
      reset = 1'b0;
      chk("abort_dump_valid", dump_valid, 0);
      chk("abort_dump_busy", dump_busy, 0);
      chk("abort_dump_addr", dump_addr, 0);
      chk("abort_dump_data", dump_data, 0);
      chk("abort_host_ack", host_ack, 0);
      got = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (dump_valid) got++;
      end
      chk("abort_no_more_pulses", got, 0);
    end else begin
      chk("dump_count", got, NUM_REGS);
      chk("dump_span", last_c - first_c, NUM_REGS - 1 + nstall);
    end
  endtask

  initial begin
    reset = 1'b1;
    core_write = 1'b0; core_wrAddr = '0; core_wrData = '0;
    core_rdAddrA = '0; core_rdAddrB = '0; core_rdB_en = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    dump_start = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem[i] = 32'hBAD0_0000 | i;   // RAM powers up with garbage
      shadow[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_dump_busy", dump_busy, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_addr", dump_addr, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_state", dbg_state, 0);

    // port A passthrough
    core_rdAddrA = 5'd19;
    #1 chk("rdAddrA_pass", rf_rdAddrA, 19);

    // preload x[i] = i*0x01010101 through the core write port
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      core_write = 1'b1; core_wrAddr = i[ADDR_W-1:0]; core_wrData = i * 32'h0101_0101;
      #1;
      if (i == 0 || i == 31) chk("preload_rf_write", rf_write, (i != 0) ? 1 : 0);
      if (i != 0) shadow[i] = i * 32'h0101_0101;
    end
    @(negedge clk);
    core_write = 1'b0;

    // dump with three scattered core stalls on port B
    run_dump(5, 12, 20, 3, 0);

    // host write then read-back of x5
    host_write(5'd5, 32'hDEADBEEF);
    host_read(5'd5, 32'hDEADBEEF);

    // host write to x7 blocked by three cycles of core writes to x10..x12
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7; host_wdata = 32'h0000_0077;
    for (int k = 0; k < 3; k++) begin
      core_write = 1'b1; core_wrAddr = 5'd10 + k[ADDR_W-1:0]; core_wrData = 32'hA0 + k;
      #1;
      chk("blk_rf_wrAddr", rf_wrAddr, 10 + k);
      chk("blk_rf_wrData", rf_wrData, 32'hA0 + k);
      chk("blk_rf_write", rf_write, 1);
      chk("blk_no_ack", host_ack, 0);
      shadow[10 + k] = 32'hA0 + k;
      @(negedge clk);
    end
    core_write = 1'b0;
    #1;
    chk("blk_host_wrAddr", rf_wrAddr, 7);
    chk("blk_host_wrData", rf_wrData, 32'h77);
    chk("blk_host_write", rf_write, 1);
    chk("blk_ack_not_yet", host_ack, 0);
    @(negedge clk);
    chk("blk_ack", host_ack, 1);
    host_req = 1'b0;
    shadow[7] = 32'h77;
    chk("blk_mem_x10", mem[10], 32'hA0);
    chk("blk_mem_x12", mem[12], 32'hA2);
    chk("blk_mem_x7", mem[7], 32'h77);

    // writes to x0 are dropped, x0 reads as zero despite RAM garbage
    host_write(5'd0, 32'h12345678);
    chk("x0_mem_untouched", mem[0], 32'hBAD0_0000);
    host_read(5'd0, 32'h0);

    // host read of x9 in the same cycle as a core write to x9
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd9;
    core_write = 1'b1; core_wrAddr = 5'd9; core_wrData = 32'hCAFEF00D;
    #1;
    chk("fwd_rdAddrB", rf_rdAddrB, 9);
    @(negedge clk);
    core_write = 1'b0;
    chk("fwd_ack_early", host_ack, 0);
    @(negedge clk);
    chk("fwd_ack", host_ack, 1);
    chk("fwd_rdata", host_rdata, 32'hCAFEF00D);
    host_req = 1'b0;
    shadow[9] = 32'hCAFEF00D;

    // reset during a dump after ten pulses, then a clean full dump
    run_dump(0, 0, 0, 0, 10);
    run_dump(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
